// File: rtl/mini_cpu_pkg.sv
// mini_cpu_pkg: shared types for the multi-cycle mini CPU.
//   opcode_e : 4-bit instruction opcodes
//   instr_t  : decoded view of a 16-bit instruction word
//   state_e  : control FSM states (also exported on the dbg_state port)
package mini_cpu_pkg;

    typedef enum logic [3:0] {
        OP_ADD   = 4'h0,
        OP_SUB   = 4'h1,
        OP_SLL   = 4'h2,
        OP_SRL   = 4'h3,
        OP_MUL   = 4'h4,
        OP_DIV   = 4'h5,
        OP_ADDI  = 4'h6,
        OP_SUBI  = 4'h7,
        OP_LOAD  = 4'h8,
        OP_STORE = 4'h9,
        OP_MOV   = 4'hA,
        OP_BEQ   = 4'hB,
        OP_BNE   = 4'hC,
        OP_JMP   = 4'hD,
        OP_ILL   = 4'hE,
        OP_HALT  = 4'hF
    } opcode_e;

    typedef struct packed {
        opcode_e    opcode;
        logic [3:0] rd;
        logic [3:0] rs1;
        logic [3:0] imm;   // rs2 index for register-register ops
    } instr_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_EXEC  = 3'd2,
        ST_MEM   = 3'd3,
        ST_HALT  = 3'd4
    } state_e;

endpackage

// File: rtl/mini_cpu_alu.sv
// mini_cpu_alu: combinational ALU for the mini CPU.
//   op  : instruction opcode
//   a   : R[rs1]
//   b   : R[rs2]
//   imm : 4-bit immediate, zero-extended for ADDI/SUBI
//   y   : result, modulo 2^XLEN (MOV passes a through)
module mini_cpu_alu
    import mini_cpu_pkg::*;
#(
    parameter int XLEN = 16
) (
    input  opcode_e          op,
    input  logic [XLEN-1:0]  a,
    input  logic [XLEN-1:0]  b,
    input  logic [3:0]       imm,
    output logic [XLEN-1:0]  y
);

    localparam int SHW = $clog2(XLEN);

    logic [XLEN-1:0] imm_z;
    logic [SHW-1:0]  shamt;

    assign imm_z = XLEN'(imm);
    assign shamt = b[SHW-1:0];

    always_comb begin
        y = '0;
        case (op)
            OP_ADD:  y = a + b;
            OP_SUB:  y = a - b;
            OP_SLL:  y = a << shamt;
            OP_SRL:  y = a >> shamt;
            OP_MUL:  y = a * b;
            // Divide by zero saturates to all-ones rather than trapping.
            OP_DIV:  y = (b == '0) ? '1 : a / b;
            OP_ADDI: y = a + imm_z;
            OP_SUBI: y = a - imm_z;
            OP_MOV:  y = a;
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/mini_cpu_mc.sv
// mini_cpu_mc: multi-cycle mini CPU (FETCH -> EXEC [-> MEM]).
//   clk, reset          : clock, synchronous active-high reset
//   prog_we/addr/data   : instruction memory load port, honoured only when not busy
//   start               : run from PC=0 when idle or halted
//   dbg_addr, dbg_data  : registered register read-back (1-cycle latency)
//   busy, halted, err   : run status; err marks a halt on the illegal opcode
//   retire              : one pulse per completed instruction
//   pc                  : current program counter
//   dbg_state           : current FSM state
// Handshake: there is no valid/ready pair; start and prog_we are level
// strobes sampled on each rising edge and simply dropped while busy=1.
module mini_cpu_mc
    import mini_cpu_pkg::*;
#(
    parameter int XLEN       = 16,
    parameter int NREG       = 8,
    parameter int IMEM_DEPTH = 16,
    parameter int DMEM_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          prog_we,
    input  logic [$clog2(IMEM_DEPTH)-1:0] prog_addr,
    input  logic [15:0]                   prog_data,
    input  logic                          start,
    input  logic [3:0]                    dbg_addr,
    output logic [XLEN-1:0]               dbg_data,
    output logic                          busy,
    output logic                          halted,
    output logic                          err,
    output logic                          retire,
    output logic [$clog2(IMEM_DEPTH)-1:0] pc,
    output state_e                        dbg_state
);

    localparam int PW = $clog2(IMEM_DEPTH);
    localparam int DW = $clog2(DMEM_DEPTH);
    localparam int RW = $clog2(NREG);

    state_e          state, state_n;
    instr_t          ir;
    logic [15:0]     imem [IMEM_DEPTH];
    logic [XLEN-1:0] dmem [DMEM_DEPTH];
    logic [XLEN-1:0] regs [NREG];

    logic [RW-1:0]   rd_i, rs1_i, rs2_i, dbg_i;
    logic [XLEN-1:0] rd_v, rs1_v, rs2_v, alu_y, wb_data;
    logic [DW-1:0]   dm_addr;
    logic [PW-1:0]   pc_n, pc_inc, pc_br, pc_jmp;
    logic            wb_en, dm_we, retire_c, err_n;

    // Register fields wrap modulo NREG so any 4-bit field is a legal index.
    function automatic logic [RW-1:0] ridx(input logic [3:0] f);
        return RW'(int'(f) % NREG);
    endfunction

    assign rd_i  = ridx(ir.rd);
    assign rs1_i = ridx(ir.rs1);
    assign rs2_i = ridx(ir.imm);
    assign dbg_i = ridx(dbg_addr);

    // R0 is hard-wired to zero on every read path.
    assign rd_v  = (rd_i  == '0) ? '0 : regs[rd_i];
    assign rs1_v = (rs1_i == '0) ? '0 : regs[rs1_i];
    assign rs2_v = (rs2_i == '0) ? '0 : regs[rs2_i];

    assign dm_addr = DW'(rs1_v + XLEN'(ir.imm));
    assign pc_inc  = pc + PW'(1);
    // Sign-extend to 32 bits then truncate: gives PC + sext(imm) mod IMEM_DEPTH.
    assign pc_br   = pc + PW'({{28{ir.imm[3]}}, ir.imm});
    assign pc_jmp  = PW'({ir.rs1, ir.imm});

    mini_cpu_alu #(.XLEN(XLEN)) u_alu (
        .op  (ir.opcode),
        .a   (rs1_v),
        .b   (rs2_v),
        .imm (ir.imm),
        .y   (alu_y)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n  = state;
        pc_n     = pc;
        err_n    = err;
        wb_en    = 1'b0;
        wb_data  = alu_y;
        dm_we    = 1'b0;
        retire_c = 1'b0;
        case (state)
            ST_IDLE, ST_HALT: begin
                if (start) begin
                    state_n = ST_FETCH;
                    pc_n    = '0;
                    err_n   = 1'b0;
                end
            end
            ST_FETCH: state_n = ST_EXEC;
            ST_EXEC: begin
                state_n = ST_FETCH;
                case (ir.opcode)
                    OP_ADD, OP_SUB, OP_SLL, OP_SRL, OP_MUL, OP_DIV,
                    OP_ADDI, OP_SUBI, OP_MOV: begin
                        wb_en    = 1'b1;
                        pc_n     = pc_inc;
                        retire_c = 1'b1;
                    end
                    OP_LOAD, OP_STORE: state_n = ST_MEM;
                    OP_BEQ: begin
                        pc_n     = (rd_v == rs1_v) ? pc_br : pc_inc;
                        retire_c = 1'b1;
                    end
                    OP_BNE: begin
                        pc_n     = (rd_v != rs1_v) ? pc_br : pc_inc;
                        retire_c = 1'b1;
                    end
                    OP_JMP: begin
                        pc_n     = pc_jmp;
                        retire_c = 1'b1;
                    end
                    OP_HALT: begin
                        state_n  = ST_HALT;
                        retire_c = 1'b1;
                    end
                    default: begin
                        // Illegal opcode: stop without retiring or writing anything.
                        state_n = ST_HALT;
                        err_n   = 1'b1;
                    end
                endcase
            end
            ST_MEM: begin
                state_n  = ST_FETCH;
                pc_n     = pc_inc;
                retire_c = 1'b1;
                if (ir.opcode == OP_LOAD) begin
                    wb_en   = 1'b1;
                    wb_data = dmem[dm_addr];
                end else begin
                    dm_we = 1'b1;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    assign busy      = (state == ST_FETCH) || (state == ST_EXEC) || (state == ST_MEM);
    assign halted    = (state == ST_HALT);
    // A reset cycle aborts whatever instruction is in flight, so it never retires.
    assign retire    = retire_c && !reset;
    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            pc       <= '0;
            err      <= 1'b0;
            ir       <= '0;
            dbg_data <= '0;
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else begin
            pc       <= pc_n;
            err      <= err_n;
            dbg_data <= (dbg_i == '0) ? '0 : regs[dbg_i];
            if (state == ST_FETCH) ir <= instr_t'(imem[pc]);
            if (wb_en && rd_i != '0) regs[rd_i] <= wb_data;
        end
    end

    // Memories are not reset; reset only blocks a store that is in flight.
    always_ff @(posedge clk) begin
        if (prog_we && !busy) imem[prog_addr] <= prog_data;
    end

    always_ff @(posedge clk) begin
        if (dm_we && !reset) dmem[dm_addr] <= rd_v;
    end

endmodule

// File: tb/tb_mini_cpu_mc.sv
// tb_mini_cpu_mc: directed bench for mini_cpu_mc with the default parameters.
module tb_mini_cpu_mc;
    import mini_cpu_pkg::*;

    logic        clk, reset, prog_we, start;
    logic [3:0]  prog_addr, dbg_addr, pc;
    logic [15:0] prog_data, dbg_data;
    logic        busy, halted, err, retire;
    state_e      dbg_state;

    int n_vec  = 0;
    int n_fail = 0;
    int ret_at[$];

    typedef struct {
        string             name;
        logic [15:0][15:0] prog;
        int                rreg;
        logic [15:0]       rval;
        int                rets;
        int                bsy;
        bit                err;
        int                pc;
    } vec_t;

    vec_t              vt[$];
    logic [15:0][15:0] pb;

    mini_cpu_mc dut (
        .clk       (clk),
        .reset     (reset),
        .prog_we   (prog_we),
        .prog_addr (prog_addr),
        .prog_data (prog_data),
        .start     (start),
        .dbg_addr  (dbg_addr),
        .dbg_data  (dbg_data),
        .busy      (busy),
        .halted    (halted),
        .err       (err),
        .retire    (retire),
        .pc        (pc),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // ---------------- scoreboard ----------------
    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic clr_prog();
        pb = {16{16'hF000}};
    endtask

    task automatic add_vec(input string nm, input int rreg, input logic [15:0] rval,
                           input int rets, input int bsy, input bit e, input int p);
        vec_t v;
        v.name = nm; v.prog = pb; v.rreg = rreg; v.rval = rval;
        v.rets = rets; v.bsy = bsy; v.err = e; v.pc = p;
        vt.push_back(v);
    endtask

    task automatic load_prog(input logic [15:0][15:0] p);
        for (int i = 0; i < 16; i++) begin
            prog_we = 1'b1; prog_addr = 4'(i); prog_data = p[i];
            @(posedge clk); #1;
        end
        prog_we = 1'b0;
    endtask

    // Pulses start, then counts busy cycles and retire pulses until halted.
    task automatic run_prog(input int max_cyc, output int rets, output int bsy, output bit to);
        int c;
        ret_at.delete();
        rets = 0; bsy = 0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; prog_we = 1'b0;
        c = 1;
        while (!halted && c <= max_cyc) begin
            if (busy) bsy++;
            if (retire) begin
                rets++;
                ret_at.push_back(c);
            end
            @(posedge clk); #1;
            c++;
        end
        to = !halted;
    endtask

    task automatic read_reg(input int idx, output logic [15:0] v);
        dbg_addr = 4'(idx);
        @(posedge clk); #1;
        v = dbg_data;
    endtask

    // ---------------- test ----------------
    initial begin
        int rets, bsy, c;
        bit to;
        logic [15:0] rv;

        reset = 1'b1; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
        start = 1'b0; dbg_addr = '0;

        clr_prog(); pb[0]=16'h6105; pb[1]=16'h6203; pb[2]=16'h0312;
        add_vec("add", 3, 16'h0008, 4, 8, 0, 3);
        clr_prog(); pb[0]=16'h6105; pb[1]=16'h6203; pb[2]=16'h1321;
        add_vec("sub_wrap", 3, 16'hFFFE, 4, 8, 0, 3);
        clr_prog(); pb[0]=16'h6101; pb[1]=16'h620F; pb[2]=16'h6222; pb[3]=16'h2312;
        add_vec("sll_mask", 3, 16'h0002, 5, 10, 0, 4);
        clr_prog(); pb[0]=16'h6101; pb[1]=16'h620F; pb[2]=16'h2312; pb[3]=16'h3432;
        add_vec("srl_logical", 4, 16'h0001, 5, 10, 0, 4);
        clr_prog(); pb[0]=16'h610F; pb[1]=16'h4211; pb[2]=16'h4322; pb[3]=16'h4431;
        add_vec("mul_low", 4, 16'h964F, 5, 10, 0, 4);
        clr_prog(); pb[0]=16'h610D; pb[1]=16'h6204; pb[2]=16'h5312;
        add_vec("div", 3, 16'h0003, 4, 8, 0, 3);
        clr_prog(); pb[0]=16'h610D; pb[1]=16'h5510;
        add_vec("div_zero", 5, 16'hFFFF, 3, 6, 0, 2);
        clr_prog(); pb[0]=16'h6102; pb[1]=16'h7115;
        add_vec("subi", 1, 16'hFFFD, 3, 6, 0, 2);
        clr_prog(); pb[0]=16'h6109; pb[1]=16'hA610;
        add_vec("mov", 6, 16'h0009, 3, 6, 0, 2);
        clr_prog(); pb[0]=16'h6007; pb[1]=16'h0100;
        add_vec("r0_zero", 1, 16'h0000, 3, 6, 0, 2);
        clr_prog(); pb[0]=16'h6906;
        add_vec("reg_mod_nreg", 1, 16'h0006, 2, 4, 0, 1);
        clr_prog(); pb[0]=16'hD003; pb[1]=16'h6101; pb[3]=16'h6207;
        add_vec("jmp", 2, 16'h0007, 3, 6, 0, 4);
        clr_prog(); pb[0]=16'h6104; pb[1]=16'hE111;
        add_vec("illegal", 1, 16'h0004, 1, 4, 1, 1);
        clr_prog(); pb[0]=16'h6103; pb[1]=16'hD00D; pb[2]=16'h6701;
        pb[13]=16'h7111; pb[14]=16'hC10F; pb[15]=16'hB104;
        add_vec("countdown_wrap", 1, 16'h0000, 10, 20, 0, 3);
        clr_prog(); pb[0]=16'h610F; pb[1]=16'h620B; pb[2]=16'h9213; pb[3]=16'h8502;
        add_vec("mem_addr_wrap", 5, 16'h000B, 5, 12, 0, 4);

        // Reset state
        do_reset();
        check("rst_busy", busy, 0);
        check("rst_halted", halted, 0);
        check("rst_err", err, 0);
        check("rst_retire", retire, 0);
        check("rst_pc", pc, 0);
        check("rst_dbg_data", dbg_data, 0);
        check("rst_state", dbg_state, ST_IDLE);

        // Table-driven programs
        foreach (vt[i]) begin
            do_reset();
            load_prog(vt[i].prog);
            run_prog(200, rets, bsy, to);
            check({vt[i].name, "_timeout"}, to, 0);
            check({vt[i].name, "_retires"}, rets, vt[i].rets);
            check({vt[i].name, "_busy_cycles"}, bsy, vt[i].bsy);
            check({vt[i].name, "_err"}, err, vt[i].err);
            check({vt[i].name, "_pc"}, pc, vt[i].pc);
            read_reg(vt[i].rreg, rv);
            check({vt[i].name, "_reg"}, rv, vt[i].rval);
        end

        // STORE then LOAD: each memory op retires 3 cycles after the previous retire
        do_reset();
        clr_prog(); pb[0]=16'h6105; pb[1]=16'h6203; pb[2]=16'h0312;
        pb[3]=16'h9302; pb[4]=16'h8402;
        load_prog(pb);
        run_prog(200, rets, bsy, to);
        check("ldst_timeout", to, 0);
        check("ldst_retires", rets, 6);
        if (ret_at.size() == 6) begin
            check("store_retire_cycle", ret_at[3], 9);
            check("load_retire_cycle", ret_at[4], 12);
        end else begin
            check("ldst_retire_list", ret_at.size(), 6);
        end
        read_reg(4, rv);
        check("load_r4", rv, 16'h0008);

        // Reset during MEM of a STORE to address 7
        do_reset();
        clr_prog(); pb[0]=16'h6105; pb[1]=16'h9107;
        load_prog(pb);
        run_prog(200, rets, bsy, to);
        check("seed_timeout", to, 0);
        clr_prog(); pb[0]=16'h6209; pb[1]=16'h9207;
        load_prog(pb);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        c = 0;
        while (dbg_state != ST_MEM && c < 20) begin
            @(posedge clk); #1;
            c++;
        end
        check("reach_mem", dbg_state, ST_MEM);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("abort_state", dbg_state, ST_IDLE);
        check("abort_busy", busy, 0);
        check("abort_pc", pc, 0);
        read_reg(2, rv);
        check("abort_r2", rv, 16'h0000);
        clr_prog(); pb[0]=16'h8307;
        load_prog(pb);
        run_prog(200, rets, bsy, to);
        read_reg(3, rv);
        check("dmem7_kept", rv, 16'h0005);

        // prog_we and start while busy are ignored
        do_reset();
        clr_prog(); pb[0]=16'h6105;
        for (int i = 1; i <= 6; i++) pb[i] = 16'h6221;
        load_prog(pb);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        rets = 0; c = 1;
        while (!halted && c < 60) begin
            if (retire) rets++;
            prog_we = (c == 5); prog_addr = 4'd0; prog_data = 16'h6109;
            start = (c == 9);
            @(posedge clk); #1;
            c++;
        end
        prog_we = 1'b0; start = 1'b0;
        check("busy_run_halted", halted, 1);
        check("busy_start_retires", rets, 8);
        read_reg(2, rv);
        check("busy_start_r2", rv, 16'h0006);
        run_prog(200, rets, bsy, to);
        read_reg(1, rv);
        check("busy_prog_we_r1", rv, 16'h0005);

        // prog_we and start together while halted: write lands, run starts
        prog_we = 1'b1; prog_addr = 4'd0; prog_data = 16'h6107;
        run_prog(200, rets, bsy, to);
        check("same_cycle_timeout", to, 0);
        check("same_cycle_retires", rets, 8);
        read_reg(1, rv);
        check("same_cycle_r1", rv, 16'h0007);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
